// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-flop synchronizer, debounce FSM, level plus press/release/long/repeat pulses.
// Optional auto-repeat pulses are enabled by defining BTN_AUTOREPEAT_EN.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned LONG_CYCLES     = 100000000,
  parameter int unsigned REPEAT_CYCLES   = 20000000,
  parameter bit          ACTIVE_LEVEL    = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release,
  output logic btn_long,
  output logic btn_repeat
);

  localparam logic [31:0] DB_LAST   = 32'(DEBOUNCE_CYCLES - 1);
  localparam logic [31:0] LONG_LAST = 32'(LONG_CYCLES - 1);
`ifdef BTN_AUTOREPEAT_EN
  localparam logic [31:0] RP_LAST   = 32'(REPEAT_CYCLES - 1);
`endif

  typedef enum logic [2:0] {
    IDLE,
    PRESS_DB,
    HELD,
    LONG_HELD,
    RELEASE_DB
  } state_t;

  state_t      state, state_next;
  logic        sync1, sync2;
  logic        raw, raw_s;
  logic [31:0] cnt, cnt_next;
  logic        was_long, was_long_next;
  logic        level_next, press_next, release_next, long_next, repeat_next;

  assign raw   = (btn_in == ACTIVE_LEVEL);
  assign raw_s = sync2;

  // State register together with every registered output and datapath flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1       <= 1'b0;
      sync2       <= 1'b0;
      state       <= IDLE;
      cnt         <= '0;
      was_long    <= 1'b0;
      btn_level   <= 1'b0;
      btn_press   <= 1'b0;
      btn_release <= 1'b0;
      btn_long    <= 1'b0;
      btn_repeat  <= 1'b0;
    end else begin
      sync1       <= raw;
      sync2       <= sync1;
      state       <= state_next;
      cnt         <= cnt_next;
      was_long    <= was_long_next;
      btn_level   <= level_next;
      btn_press   <= press_next;
      btn_release <= release_next;
      btn_long    <= long_next;
      btn_repeat  <= repeat_next;
    end
  end

  // Next-state logic; release wins over a long timeout on the same edge.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (raw_s) state_next = PRESS_DB;
      end
      PRESS_DB: begin
        if (!raw_s)              state_next = IDLE;
        else if (cnt == DB_LAST) state_next = HELD;
      end
      HELD: begin
        if (!raw_s)                state_next = RELEASE_DB;
        else if (cnt == LONG_LAST) state_next = LONG_HELD;
      end
      LONG_HELD: begin
        if (!raw_s) state_next = RELEASE_DB;
      end
      RELEASE_DB: begin
        if (raw_s)               state_next = was_long ? LONG_HELD : HELD;
        else if (cnt == DB_LAST) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Counter, long-hold memory and next values of the registered outputs.
  always_comb begin
    cnt_next      = '0;
    was_long_next = was_long;
    press_next    = 1'b0;
    release_next  = 1'b0;
    long_next     = 1'b0;
    repeat_next   = 1'b0;
    level_next    = (state_next == HELD) || (state_next == LONG_HELD) ||
                    (state_next == RELEASE_DB);

    if (state_next != state) begin
      cnt_next = '0;
      if (state == PRESS_DB && state_next == HELD) begin
        press_next    = 1'b1;
        was_long_next = 1'b0;
      end
      if (state == HELD && state_next == LONG_HELD) begin
        long_next     = 1'b1;
        was_long_next = 1'b1;
      end
      if (state == RELEASE_DB && state_next == IDLE) begin
        release_next = 1'b1;
      end
    end else begin
      case (state)
        PRESS_DB, HELD, RELEASE_DB: cnt_next = cnt + 32'd1;
        LONG_HELD: begin
`ifdef BTN_AUTOREPEAT_EN
          if (cnt == RP_LAST) begin
            cnt_next    = '0;
            repeat_next = 1'b1;
          end else begin
            cnt_next = cnt + 32'd1;
          end
`else
          cnt_next = cnt;
`endif
        end
        default: cnt_next = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_btn_debounce.sv
// Directed bench for btn_debounce: edge numbers of every pulse are logged and compared to hand-derived values.
module tb_btn_debounce;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn_in = 1'b0;
  logic btn_level, btn_press, btn_release, btn_long, btn_repeat;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int base = 0;
  int multi = 0;
  int press_q[$], rel_q[$], long_q[$], rep_q[$], rise_q[$], fall_q[$];
  logic level_prev = 1'b0;

  btn_debounce #(
    .DEBOUNCE_CYCLES(4),
    .LONG_CYCLES(20),
    .REPEAT_CYCLES(8),
    .ACTIVE_LEVEL(1'b1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .btn_in(btn_in),
    .btn_level(btn_level),
    .btn_press(btn_press),
    .btn_release(btn_release),
    .btn_long(btn_long),
    .btn_repeat(btn_repeat)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  // Log the relative edge number of every pulse and level change.
  always @(negedge clk) begin
    if (btn_press)   press_q.push_back(cyc - base);
    if (btn_release) rel_q.push_back(cyc - base);
    if (btn_long)    long_q.push_back(cyc - base);
    if (btn_repeat)  rep_q.push_back(cyc - base);
    if (btn_level && !level_prev) rise_q.push_back(cyc - base);
    if (!btn_level && level_prev) fall_q.push_back(cyc - base);
    if (int'(btn_press) + int'(btn_release) + int'(btn_long) + int'(btn_repeat) > 1)
      multi = multi + 1;
    level_prev = btn_level;
  end

  task automatic check(input string tag, input int got, input int exp);
    checks = checks + 1;
    if (got != exp) begin
      errors = errors + 1;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s = %0d", tag, got);
    end
  endtask

  function automatic int at(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  task automatic mark_now();
    base = cyc;
    press_q.delete(); rel_q.delete(); long_q.delete();
    rep_q.delete(); rise_q.delete(); fall_q.delete();
  endtask

  task automatic mark();
    @(negedge clk);
    #1;
    mark_now();
  endtask

  task automatic to_edge(input int k);
    while (cyc - base < k) @(negedge clk);
    #1;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_level", int'(btn_level), 0);
    check("rst_press", int'(btn_press), 0);
    check("rst_repeat", int'(btn_repeat), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Clean hold then release sampled at edge 50
    mark();
    btn_in = 1'b1;
    to_edge(49);
    btn_in = 1'b0;
    to_edge(62);
    check("t1_press_n", press_q.size(), 1);
    check("t1_press_edge", at(press_q, 0), 7);
    check("t1_rise_edge", at(rise_q, 0), 7);
    check("t1_long_n", long_q.size(), 1);
    check("t1_long_edge", at(long_q, 0), 27);
`ifdef BTN_AUTOREPEAT_EN
    check("t1_rep_n", rep_q.size(), 3);
    check("t1_rep0", at(rep_q, 0), 35);
    check("t1_rep1", at(rep_q, 1), 43);
    check("t1_rep2", at(rep_q, 2), 51);
`else
    check("t1_rep_n", rep_q.size(), 0);
`endif
    check("t3_rel_n", rel_q.size(), 1);
    check("t3_rel_edge", at(rel_q, 0), 56);
    check("t3_fall_edge", at(fall_q, 0), 56);

    // Press bounce of 3 cycles and the boundary length of DEBOUNCE_CYCLES
    mark();
    btn_in = 1'b1;
    to_edge(3);
    btn_in = 1'b0;
    to_edge(15);
    check("t2_press_n3", press_q.size(), 1'b0);
    check("t2_rise_n3", rise_q.size(), 0);
    mark();
    btn_in = 1'b1;
    to_edge(4);
    btn_in = 1'b0;
    to_edge(15);
    check("t2_press_n4", press_q.size(), 0);
    check("t2_rise_n4", rise_q.size(), 0);

    // Five-cycle pulse is the shortest one accepted
    mark();
    btn_in = 1'b1;
    to_edge(5);
    btn_in = 1'b0;
    to_edge(20);
    check("t2_press_n5", press_q.size(), 1);
    check("t2_press_edge5", at(press_q, 0), 7);
    check("t2_rel_edge5", at(rel_q, 0), 12);

    // Release bounce while HELD
    mark();
    btn_in = 1'b1;
    to_edge(10);
    btn_in = 1'b0;
    to_edge(12);
    btn_in = 1'b1;
    to_edge(45);
    check("t4_press_n", press_q.size(), 1);
    check("t4_rel_n", rel_q.size(), 0);
    check("t4_fall_n", fall_q.size(), 0);
    check("t4_long_edge", at(long_q, 0), 35);
`ifdef BTN_AUTOREPEAT_EN
    check("t4_rep_n", rep_q.size(), 1);
    check("t4_rep0", at(rep_q, 0), 43);
`else
    check("t4_rep_n", rep_q.size(), 0);
`endif
    btn_in = 1'b0;
    to_edge(60);
    check("t4_rel_edge", at(rel_q, 0), 52);

    // Asynchronous reset while LONG_HELD, button kept down
    mark();
    btn_in = 1'b1;
    to_edge(30);
    check("t5_level_pre", int'(btn_level), 1);
    #2 rst = 1'b1;
    #1;
    check("t5_level_rst", int'(btn_level), 0);
    check("t5_outs_rst", int'({btn_press, btn_release, btn_long, btn_repeat}), 0);
    @(negedge clk);
    #1;
    rst = 1'b0;
    mark_now();
    to_edge(60);
    check("t5_press_n", press_q.size(), 1);
    check("t5_press_edge", at(press_q, 0), 7);
    check("t5_rise_edge", at(rise_q, 0), 7);
    check("t6_long_n", long_q.size(), 1);
    check("t6_long_edge", at(long_q, 0), 27);
`ifdef BTN_AUTOREPEAT_EN
    check("t6_rep_n", rep_q.size(), 4);
    check("t6_rep3", at(rep_q, 3), 59);
`else
    check("t6_rep_n", rep_q.size(), 0);
`endif
    btn_in = 1'b0;
    to_edge(75);
    check("t6_level_end", int'(btn_level), 0);

    check("exclusive", multi, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
